// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks framing
// and CRC7, then serialises a 48-bit response once card logic hands one over.
module sd_cmd_responder #(
    parameter int NCR_MIN = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd,
    output logic        ocmd,
    output logic        ocmd_oe,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocmd_valid,
    output logic        ocrc_err,
    output logic        oframe_err,
    input  logic        irsp_send,
    input  logic        irsp_skip,
    input  logic [5:0]  irsp_index,
    input  logic [31:0] irsp_arg,
    output logic        obusy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_TX    = 3'd5;

    localparam int GW = $clog2(NCR_MIN + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(NCR_MIN);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    logic [2:0]    state_q, state_d;
    logic [46:0]   rx_q, rx_d;
    logic [6:0]    crc_q, crc_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]   wait_cnt_q, wait_cnt_d;
    logic [39:0]   tx_q, tx_d;
    logic          ocmd_q, ocmd_d;
    logic          oe_q, oe_d;
    logic [5:0]    index_q, index_d;
    logic [31:0]   arg_q, arg_d;
    logic          valid_q, valid_d;
    logic          crc_err_q, crc_err_d;
    logic          frame_err_q, frame_err_d;

    logic [GW-1:0] gap_inc;
    logic [39:0]   rsp_word;
    logic [39:0]   tx_src;
    logic          start_tx;

    always_comb begin
        state_d     = state_q;
        rx_d        = rx_q;
        crc_d       = crc_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_d        = tx_q;
        ocmd_d      = ocmd_q;
        oe_d        = oe_q;
        index_d     = index_q;
        arg_d       = arg_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        start_tx    = 1'b0;
        tx_src      = tx_q;
        rsp_word    = {2'b00, irsp_index, irsp_arg};
        gap_inc     = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!icmd) begin
                    state_d   = S_RX;
                    rx_d      = {rx_q[45:0], icmd};
                    crc_d     = crc7_step(7'd0, icmd);
                    bit_cnt_d = 6'd1;
                end
            end
            // The start bit falls off the top, leaving direction..end in rx_q
            S_RX: begin
                rx_d      = {rx_q[45:0], icmd};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q < 6'd40) begin
                    crc_d = crc7_step(crc_q, icmd);
                end
                if (bit_cnt_q == 6'd47) begin
                    state_d   = S_CHECK;
                    gap_cnt_d = '0;
                end
            end
            S_CHECK: begin
                gap_cnt_d = gap_inc;
                if (!rx_q[46] || !rx_q[0]) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (rx_q[7:1] != crc_q) begin
                    crc_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    index_d    = rx_q[45:40];
                    arg_d      = rx_q[39:8];
                    valid_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                gap_cnt_d = gap_inc;
                if (irsp_skip) begin
                    state_d = S_IDLE;
                end else if (irsp_send) begin
                    if (gap_cnt_q >= GAP_MAX) begin
                        start_tx = 1'b1;
                        tx_src   = rsp_word;
                    end else begin
                        tx_d    = rsp_word;
                        state_d = S_GAP;
                    end
                end else if (TIMEOUT > 0 && wait_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_inc;
                if (gap_cnt_q >= GAP_MAX) begin
                    start_tx = 1'b1;
                    tx_src   = tx_q;
                end
            end
            // Bits 1..39 come from tx_q, 40..46 from the running CRC, 47 is the end bit
            S_TX: begin
                if (bit_cnt_q == 6'd48) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    ocmd_d  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q < 6'd40) begin
                        ocmd_d = tx_q[39];
                        crc_d  = crc7_step(crc_q, tx_q[39]);
                        tx_d   = {tx_q[38:0], 1'b0};
                    end else if (bit_cnt_q < 6'd47) begin
                        ocmd_d = crc_q[6];
                        crc_d  = {crc_q[5:0], 1'b0};
                    end else begin
                        ocmd_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start bit is driven on the same edge that enters TX; it is always 0 and leaves CRC at 0
        if (start_tx) begin
            state_d   = S_TX;
            oe_d      = 1'b1;
            ocmd_d    = tx_src[39];
            crc_d     = crc7_step(7'd0, tx_src[39]);
            tx_d      = {tx_src[38:0], 1'b0};
            bit_cnt_d = 6'd1;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= S_IDLE;
            rx_q        <= '0;
            crc_q       <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            tx_q        <= '0;
            ocmd_q      <= 1'b1;
            oe_q        <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            crc_q       <= crc_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_q        <= tx_d;
            ocmd_q      <= ocmd_d;
            oe_q        <= oe_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ocmd       = ocmd_q;
    assign ocmd_oe    = oe_q;
    assign ocmd_index = index_q;
    assign ocmd_arg   = arg_q;
    assign ocmd_valid = valid_q;
    assign ocrc_err   = crc_err_q;
    assign oframe_err = frame_err_q;
    assign obusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: stimulus pushes expected pulses and
// response frames, a negedge monitor pops and compares them as the DUT emits them.
module tb_sd_cmd_responder;

    localparam int NCR_MIN = 2;
    localparam int TIMEOUT = 64;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        icmd = 1'b1;
    logic        irsp_send = 1'b0;
    logic        irsp_skip = 1'b0;
    logic [5:0]  irsp_index = '0;
    logic [31:0] irsp_arg = '0;
    logic        ocmd, ocmd_oe, ocmd_valid, ocrc_err, oframe_err, obusy;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;

    sd_cmd_responder #(.NCR_MIN(NCR_MIN), .TIMEOUT(TIMEOUT)) dut (
        .iclk(iclk), .irst(irst), .icmd(icmd),
        .ocmd(ocmd), .ocmd_oe(ocmd_oe),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
        .ocmd_valid(ocmd_valid), .ocrc_err(ocrc_err), .oframe_err(oframe_err),
        .irsp_send(irsp_send), .irsp_skip(irsp_skip),
        .irsp_index(irsp_index), .irsp_arg(irsp_arg),
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [5:0]  idx;
        logic [31:0] arg;
    } rx_exp_t;

    typedef struct {
        logic [47:0] frame;
        int          delay;
    } tx_exp_t;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_CRC   = 3'b010;
    localparam logic [2:0] K_FRAME = 3'b100;

    rx_exp_t rx_exp_q[$];
    tx_exp_t tx_exp_q[$];
    rx_exp_t mon_rx;
    tx_exp_t mon_tx;

    int tests = 0;
    int fails = 0;
    int last_end_cyc = 0;
    int tx_done = 0;
    int abort_req = 0;
    int abort_ack = 0;
    bit in_tx = 1'b0;
    logic [47:0] tx_bits = '0;
    int tx_len = 0;
    int tx_start = 0;
    bit ok;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: receive-side pulses and transmitted response frames
    always @(negedge iclk) begin
        if (ocmd_valid || ocrc_err || oframe_err) begin
            if (rx_exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {61'd0, oframe_err, ocrc_err, ocmd_valid}, 64'd0);
            end else begin
                mon_rx = rx_exp_q.pop_front();
                checkOutput("pulse_kind", {61'd0, oframe_err, ocrc_err, ocmd_valid}, {61'd0, mon_rx.kind});
                if (mon_rx.kind == K_VALID) begin
                    checkOutput("cmd_index", {58'd0, ocmd_index}, {58'd0, mon_rx.idx});
                    checkOutput("cmd_arg", {32'd0, ocmd_arg}, {32'd0, mon_rx.arg});
                end
            end
        end
        if (ocmd_oe) begin
            if (!in_tx) begin
                in_tx    = 1'b1;
                tx_start = cyc;
                tx_len   = 0;
                tx_bits  = '0;
            end
            tx_bits = {tx_bits[46:0], ocmd};
            tx_len++;
        end else if (in_tx) begin
            in_tx = 1'b0;
            tx_done++;
            if (abort_req != abort_ack) begin
                abort_ack = abort_req;
            end else if (tx_exp_q.size() == 0) begin
                checkOutput("unexpected_tx", 64'd1, 64'd0);
            end else begin
                mon_tx = tx_exp_q.pop_front();
                checkOutput("rsp_frame", {16'd0, tx_bits}, {16'd0, mon_tx.frame});
                checkOutput("rsp_oe_len", 64'(tx_len), 64'd48);
                checkOutput("rsp_start_delay", 64'(tx_start - (last_end_cyc + 1)), 64'(mon_tx.delay));
                checkOutput("cmd_idle_after_tx", {63'd0, ocmd}, 64'd1);
            end
        end
    end

    task automatic applyStimulus(input logic [47:0] frame, input logic [2:0] kind,
                                 input logic [5:0] idx, input logic [31:0] arg);
        rx_exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.arg  = arg;
        rx_exp_q.push_back(e);
        for (int i = 47; i >= 0; i--) begin
            @(negedge iclk);
            icmd = frame[i];
        end
        last_end_cyc = cyc;
        @(negedge iclk);
        icmd = 1'b1;
    endtask

    task automatic expectResponse(input logic [47:0] frame);
        tx_exp_t t;
        t.frame = frame;
        t.delay = NCR_MIN + 1;
        tx_exp_q.push_back(t);
    endtask

    task automatic waitValid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iclk);
            if (ocmd_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("valid_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic waitTxDone();
        int start;
        bit done;
        start = tx_done;
        done  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge iclk);
            if (tx_done != start) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("tx_completed", {63'd0, done}, 64'd1);
    endtask

    task automatic pulseHandshake(input bit send, input bit skip,
                                  input logic [5:0] idx, input logic [31:0] arg);
        irsp_send  = send;
        irsp_skip  = skip;
        irsp_index = idx;
        irsp_arg   = arg;
        @(negedge iclk);
        irsp_send = 1'b0;
        irsp_skip = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge iclk);
        checkOutput("rst_ocmd", {63'd0, ocmd}, 64'd1);
        checkOutput("rst_oe", {63'd0, ocmd_oe}, 64'd0);
        checkOutput("rst_index", {58'd0, ocmd_index}, 64'd0);
        checkOutput("rst_arg", {32'd0, ocmd_arg}, 64'd0);
        checkOutput("rst_pulses", {61'd0, oframe_err, ocrc_err, ocmd_valid}, 64'd0);
        checkOutput("rst_busy", {63'd0, obusy}, 64'd0);
        irst = 1'b0;
        @(negedge iclk);

        // CMD0, then drop it with a skip
        applyStimulus(48'h400000000095, K_VALID, 6'd0, 32'h0);
        waitValid(ok);
        pulseHandshake(1'b0, 1'b1, 6'd0, 32'h0);
        checkOutput("busy_after_skip", {63'd0, obusy}, 64'd0);

        // CMD8 answered on the cycle after ocmd_valid
        applyStimulus(48'h48000001AA87, K_VALID, 6'd8, 32'h000001AA);
        expectResponse(48'h08000001AA13);
        waitValid(ok);
        @(negedge iclk);
        pulseHandshake(1'b1, 1'b0, 6'd8, 32'h000001AA);
        waitTxDone();

        // CMD55 answered in the ocmd_valid cycle itself: must wait out the gap
        applyStimulus(48'h770000000065, K_VALID, 6'd55, 32'h0);
        expectResponse(48'h000000000001);
        waitValid(ok);
        pulseHandshake(1'b1, 1'b0, 6'd0, 32'h0);
        waitTxDone();

        // CMD17 with the last CRC bit flipped, then back-to-back framing errors
        applyStimulus(48'h510000000057, K_CRC, 6'd0, 32'h0);
        @(negedge iclk);
        @(negedge iclk);
        checkOutput("busy_after_crc_err", {63'd0, obusy}, 64'd0);
        applyStimulus(48'h400000000094, K_FRAME, 6'd0, 32'h0);
        applyStimulus(48'h000000000095, K_FRAME, 6'd0, 32'h0);
        @(negedge iclk);
        @(negedge iclk);

        // Valid CMD17, no handshake: timeout after TIMEOUT clocks in WAIT
        applyStimulus(48'h510000000055, K_VALID, 6'd17, 32'h0);
        waitValid(ok);
        repeat (TIMEOUT - 1) @(negedge iclk);
        checkOutput("busy_before_timeout", {63'd0, obusy}, 64'd1);
        @(negedge iclk);
        checkOutput("busy_after_timeout", {63'd0, obusy}, 64'd0);

        // ACMD41 with skip and send together: no response
        applyStimulus(48'h694000000077, K_VALID, 6'd41, 32'h40000000);
        waitValid(ok);
        @(negedge iclk);
        pulseHandshake(1'b1, 1'b1, 6'd41, 32'h00FF8000);
        checkOutput("busy_after_skip_send", {63'd0, obusy}, 64'd0);
        repeat (10) @(negedge iclk);

        // Reset while transmitting bit 20 of a CMD8 response
        applyStimulus(48'h48000001AA87, K_VALID, 6'd8, 32'h000001AA);
        waitValid(ok);
        @(negedge iclk);
        pulseHandshake(1'b1, 1'b0, 6'd8, 32'h000001AA);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ocmd_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge iclk);
        end
        checkOutput("tx_started", {63'd0, ok}, 64'd1);
        repeat (20) @(negedge iclk);
        abort_req = abort_req + 1;
        irst = 1'b1;
        @(negedge iclk);
        irst = 1'b0;
        checkOutput("abort_oe", {63'd0, ocmd_oe}, 64'd0);
        checkOutput("abort_ocmd", {63'd0, ocmd}, 64'd1);
        checkOutput("abort_busy", {63'd0, obusy}, 64'd0);
        checkOutput("abort_index", {58'd0, ocmd_index}, 64'd0);
        checkOutput("abort_arg", {32'd0, ocmd_arg}, 64'd0);
        @(negedge iclk);

        // Normal reception after the reset
        applyStimulus(48'h400000000095, K_VALID, 6'd0, 32'h0);
        waitValid(ok);
        pulseHandshake(1'b0, 1'b1, 6'd0, 32'h0);
        repeat (5) @(negedge iclk);

        checkOutput("rx_queue_drained", 64'(rx_exp_q.size()), 64'd0);
        checkOutput("tx_queue_drained", 64'(tx_exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side endpoint of the SD CMD line: the counterpart to the host transceiver's CMD driver.
- Deserialises 48-bit host command frames and checks framing and CRC7.
- Hands index/argument to card logic, then serialises a 48-bit response frame back onto CMD.
- Used in the SD card emulator and as a synthesizable loopback partner for host-side verification.

Parameters:
NCR_MIN, 2, minimum idle clocks between command end bit and response start bit (range 2..64)
TIMEOUT, 64, clocks to wait for the response handshake before abandoning the command (0 = wait forever)

Ports:
iclk  input  1  SD CLK; all sampling and driving on rising edge
irst  input  1  synchronous active-high reset
icmd  input  1  sampled CMD line level
ocmd  output  1  CMD value to drive
ocmd_oe  output  1  CMD output enable; 1 only while transmitting a response
ocmd_index  output  6  received command index
ocmd_arg  output  32  received command argument
ocmd_valid  output  1  one-cycle pulse; good command received
ocrc_err  output  1  one-cycle pulse; CRC7 mismatch
oframe_err  output  1  one-cycle pulse; transmission or end bit wrong
irsp_send  input  1  request to send response; sampled in WAIT only
irsp_skip  input  1  drop the command with no response; sampled in WAIT only
irsp_index  input  6  response index field
irsp_arg  input  32  response 32-bit payload
obusy  output  1  1 in any state except IDLE

Behaviour:
- Reset values: ocmd=1, ocmd_oe=0, ocmd_index=0, ocmd_arg=0, all pulses 0, obusy=0, state IDLE.
- Frame format, MSB first: start 0, direction bit, index[5:0], arg[31:0], CRC7[6:0], end 1.
  - Command direction bit = 1. Response direction bit = 0.
- CRC7 uses polynomial x^7+x^3+1 with init 0. It covers the first 40 bits of the frame.
- IDLE:
  - icmd=0 is taken as the start bit; go to RX with bit counter=1.
  - icmd=1 stays in IDLE.
- RX:
  - Shift icmd into a 48-bit register each clock and update CRC over bits 0..39.
  - After bit 47 is sampled, go to CHECK.
- CHECK (1 clock):
  - Direction bit != 1 or end bit != 1: pulse oframe_err and go to IDLE. Frame error takes priority over CRC error.
  - Otherwise, CRC mismatch: pulse ocrc_err and go to IDLE.
  - Otherwise: latch ocmd_index/ocmd_arg, pulse ocmd_valid, go to WAIT.
  - ocmd_index/ocmd_arg hold until the next good command.
- WAIT:
  - A gap counter starts at the command end bit and saturates at NCR_MIN.
  - irsp_skip=1 goes to IDLE. Skip wins if it is asserted together with irsp_send.
  - irsp_send=1 latches irsp_index/irsp_arg, then:
    - counter >= NCR_MIN: go to TX.
    - counter < NCR_MIN: go to GAP until it reaches NCR_MIN.
  - With TIMEOUT>0 and no handshake within TIMEOUT clocks of entering WAIT, go to IDLE silently.
  - Handshake inputs are ignored in every other state.
- TX:
  - ocmd_oe=1 for exactly 48 clocks, driving the response frame with CRC7 computed on the fly.
  - The next clock returns to IDLE with ocmd_oe=0 and ocmd=1.
  - icmd is ignored during WAIT, GAP and TX. The line is half-duplex and the host must not drive it.
- Latency:
  - ocmd_valid is asserted 1 clock after the end bit is sampled.
  - The response start bit appears no earlier than NCR_MIN+1 clocks after the end bit.
- Back-to-back commands:
  - A new start bit is accepted on the clock immediately after returning to IDLE.
  - A frame that started while busy is not recovered.
- irst in any state: the next edge applies reset values, ocmd_oe drops, and latched handshake data is discarded.

Test Plan:
- Send CMD0 frame 0x400000000095 -> ocmd_valid pulse with index 0, arg 0x00000000; no error pulses.
- Send CMD8 frame 0x48000001AA87, answer irsp_send with index 8, arg 0x000001AA on the cycle after ocmd_valid -> CMD carries 0x08000001AA13 with ocmd_oe high for exactly 48 clocks, starting NCR_MIN+1 clocks after the end bit.
- Send CMD17 frame 0x510000000055 with the last CRC bit flipped -> ocrc_err pulse, no ocmd_valid, obusy low 1 clock later.
- Send a frame with end bit 0 and valid CRC -> oframe_err only. Send a frame with direction bit 0 -> oframe_err only.
- Valid command with no handshake, TIMEOUT=64 -> returns to IDLE 64 clocks after WAIT entry and ocmd_oe never rises. Assert irsp_skip and irsp_send in the same cycle -> no response.
- Assert irst at TX bit 20 -> ocmd_oe=0, ocmd=1 on the next edge. The following CMD0 frame is received normally.
